// File: rtl/dmem_responder.sv
// Byte-addressed data memory with a fixed-latency valid/ready request/response
// handshake, RV32I load/store sizing, sign/zero extension and error reporting.
module dmem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // With a single-cycle latency the access happens on the accepting edge itself,
  // so it must use the live request rather than the captured copy.
  localparam bit DIRECT = (LATENCY == 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]  state_reg;
  logic [3:0]  cnt_reg;
  logic        cap_we_reg;
  logic [2:0]  cap_funct3_reg;
  logic [31:0] cap_addr_reg;
  logic [31:0] cap_wdata_reg;
  logic        rsp_valid_reg;
  logic [31:0] rsp_rdata_reg;
  logic        rsp_err_reg;

  logic [7:0]  mem_reg [DEPTH];

  logic        accept;
  logic        enter_resp;
  logic        acc_we;
  logic [2:0]  acc_funct3;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [1:0]  acc_last;
  logic        funct3_ok;
  logic        misaligned;
  logic [32:0] end_addr;
  logic        out_of_range;
  logic        acc_err;
  logic        commit;
  logic [3:0]  wr_lane_en;
  logic [3:0][AW-1:0] byte_idx;
  logic [3:0][7:0]    rd_byte;
  logic [31:0] ext_data;
  logic [31:0] load_data;

  assign req_ready = (state_reg == IDLE) && !reset;
  assign accept    = req_valid && req_ready;

  assign acc_we     = DIRECT ? req_we     : cap_we_reg;
  assign acc_funct3 = DIRECT ? req_funct3 : cap_funct3_reg;
  assign acc_addr   = DIRECT ? req_addr   : cap_addr_reg;
  assign acc_wdata  = DIRECT ? req_wdata  : cap_wdata_reg;

  assign enter_resp = DIRECT ? (state_reg == IDLE && accept)
                             : (state_reg == WAIT && cnt_reg == 4'd0);

  always_comb begin
    acc_last   = 2'd0;
    misaligned = 1'b0;
    case (acc_funct3[1:0])
      2'b01: begin
        acc_last   = 2'd1;
        misaligned = acc_addr[0];
      end
      2'b10: begin
        acc_last   = 2'd3;
        misaligned = |acc_addr[1:0];
      end
      default: acc_last = 2'd0;
    endcase
    if (acc_we)
      funct3_ok = acc_funct3 inside {3'b000, 3'b001, 3'b010};
    else
      funct3_ok = !(acc_funct3 inside {3'b011, 3'b110, 3'b111});
    // One extra bit keeps the last-byte address from wrapping near 2^32.
    end_addr     = {1'b0, acc_addr} + 33'(acc_last);
    out_of_range = end_addr >= 33'(DEPTH);
    acc_err      = !funct3_ok || misaligned || out_of_range;
  end

  assign commit = enter_resp && acc_we && !acc_err;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign byte_idx[gi]   = acc_addr[AW-1:0] + AW'(gi);
      assign rd_byte[gi]    = mem_reg[byte_idx[gi]];
      assign wr_lane_en[gi] = commit && (2'(gi) <= acc_last);
    end
  endgenerate

  always_comb begin
    ext_data = 32'd0;
    case (acc_funct3)
      3'b000:  ext_data = {{24{rd_byte[0][7]}}, rd_byte[0]};
      3'b001:  ext_data = {{16{rd_byte[1][7]}}, rd_byte[1], rd_byte[0]};
      3'b010:  ext_data = rd_byte;
      3'b100:  ext_data = {24'd0, rd_byte[0]};
      3'b101:  ext_data = {16'd0, rd_byte[1], rd_byte[0]};
      default: ext_data = 32'd0;
    endcase
    load_data = (acc_we || acc_err) ? 32'd0 : ext_data;
  end

  // Each byte resets to its own low address bits so contents are known after reset.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
      always_ff @(posedge clk) begin
        if (reset) begin
          mem_reg[gi] <= 8'(gi);
        end else begin
          for (int k = 0; k < 4; k++) begin
            if (wr_lane_en[k] && byte_idx[k] == AW'(gi))
              mem_reg[gi] <= acc_wdata[8*k +: 8];
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      cnt_reg        <= 4'd0;
      cap_we_reg     <= 1'b0;
      cap_funct3_reg <= 3'd0;
      cap_addr_reg   <= 32'd0;
      cap_wdata_reg  <= 32'd0;
      rsp_valid_reg  <= 1'b0;
      rsp_rdata_reg  <= 32'd0;
      rsp_err_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            cap_we_reg     <= req_we;
            cap_funct3_reg <= req_funct3;
            cap_addr_reg   <= req_addr;
            cap_wdata_reg  <= req_wdata;
            if (DIRECT) begin
              state_reg <= RESP;
            end else begin
              state_reg <= WAIT;
              cnt_reg   <= 4'(LATENCY - 2);
            end
          end
        end
        WAIT: begin
          if (cnt_reg == 4'd0)
            state_reg <= RESP;
          else
            cnt_reg <= cnt_reg - 4'd1;
        end
        RESP: begin
          if (rsp_ready) begin
            state_reg     <= IDLE;
            rsp_valid_reg <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
      if (enter_resp) begin
        rsp_valid_reg <= 1'b1;
        rsp_rdata_reg <= load_data;
        rsp_err_reg   <= acc_err;
      end
    end
  end

  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: loads, stores, extension, errors,
// response backpressure and reset during an outstanding access.
module tb_dmem_responder;

  localparam int DEPTH   = 1024;
  localparam int LATENCY = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int pass_cnt  = 0;
  int total_cnt = 0;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Called at a falling edge: presents the request, lets the next rising edge
  // accept it, then waits (bounded) for the response and checks it.
  task automatic send(input string tag, input logic we, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_err);
    int lat;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    rsp_ready  = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "/latency"}, 32'(lat), 32'(LATENCY));
    check({tag, "/rdata"}, rsp_rdata, exp_rdata);
    check({tag, "/err"}, 32'(rsp_err), 32'(exp_err));
    $display("txn %s we=%0d f3=%0d addr=0x%08h wdata=0x%08h -> rdata=0x%08h err=%0d lat=%0d",
             tag, we, f3, addr, wdata, rsp_rdata, rsp_err, lat);
  endtask

  task automatic txn(input string tag, input logic we, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rdata, input logic exp_err);
    @(negedge clk);
    check({tag, "/ready"}, 32'(req_ready), 32'd1);
    send(tag, we, f3, addr, wdata, exp_rdata, exp_err);
  endtask

  initial begin
    int lat;
    logic seen_valid;

    reset      = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    rsp_ready  = 1'b0;

    // Reset behaviour
    repeat (3) @(negedge clk);
    check("reset/ready_low", 32'(req_ready), 32'd0);
    reset = 1'b0;
    #1;
    check("reset/ready_first", 32'(req_ready), 32'd1);
    check("reset/rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset/rsp_rdata", rsp_rdata, 32'd0);
    check("reset/rsp_err", 32'(rsp_err), 32'd0);

    // Loads from reset contents and extension
    txn("lw4",    1'b0, 3'b010, 32'd4,     32'd0, 32'h0706_0504, 1'b0);
    txn("lb80",   1'b0, 3'b000, 32'h80,    32'd0, 32'hFFFF_FF80, 1'b0);
    txn("lbu80",  1'b0, 3'b100, 32'h80,    32'd0, 32'h0000_0080, 1'b0);
    txn("lhuFE",  1'b0, 3'b101, 32'hFE,    32'd0, 32'h0000_FFFE, 1'b0);
    txn("lw1020", 1'b0, 3'b010, 32'd1020,  32'd0, 32'hFFFE_FDFC, 1'b0);

    // Stores followed by loads
    txn("sw8",    1'b1, 3'b010, 32'd8,     32'hDEAD_BEEF, 32'd0, 1'b0);
    txn("lh10",   1'b0, 3'b001, 32'd10,    32'd0, 32'hFFFF_DEAD, 1'b0);
    txn("lb8",    1'b0, 3'b000, 32'd8,     32'd0, 32'hFFFF_FFEF, 1'b0);
    txn("sh40",   1'b1, 3'b001, 32'h40,    32'hCAFE_1234, 32'd0, 1'b0);
    txn("lw40",   1'b0, 3'b010, 32'h40,    32'd0, 32'h4342_1234, 1'b0);
    txn("sb21",   1'b1, 3'b000, 32'h21,    32'h1234_5678, 32'd0, 1'b0);
    txn("lw20",   1'b0, 3'b010, 32'h20,    32'd0, 32'h2322_7820, 1'b0);

    // Error cases
    txn("lw2_mis",   1'b0, 3'b010, 32'd2,    32'd0, 32'd0, 1'b1);
    txn("lh3_mis",   1'b0, 3'b001, 32'd3,    32'd0, 32'd0, 1'b1);
    txn("sw1022",    1'b1, 3'b010, 32'd1022, 32'h1122_3344, 32'd0, 1'b1);
    txn("lhu1022",   1'b0, 3'b101, 32'd1022, 32'd0, 32'h0000_FFFE, 1'b0);
    txn("lb1024",    1'b0, 3'b000, 32'd1024, 32'd0, 32'd0, 1'b1);
    txn("lwrap",     1'b0, 3'b000, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b1);
    txn("ld_f3_011", 1'b0, 3'b011, 32'd0,    32'd0, 32'd0, 1'b1);
    txn("st_f3_100", 1'b1, 3'b100, 32'd48,   32'h0000_0099, 32'd0, 1'b1);
    txn("lbu48",     1'b0, 3'b100, 32'd48,   32'd0, 32'h0000_0030, 1'b0);

    // Backpressure: response held while rsp_ready is low
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'd4;
    rsp_ready  = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("bp/latency", 32'(lat), 32'(LATENCY));
    for (int i = 0; i < 3; i++) begin
      check("bp/valid_hold", 32'(rsp_valid), 32'd1);
      check("bp/rdata_hold", rsp_rdata, 32'h0706_0504);
      check("bp/ready_low", 32'(req_ready), 32'd0);
      req_valid  = (i == 1);
      req_we     = 1'b1;
      req_funct3 = 3'b000;
      req_addr   = 32'h80;
      req_wdata  = 32'h0000_0055;
      @(negedge clk);
    end
    req_valid = 1'b0;
    check("bp/valid_after3", 32'(rsp_valid), 32'd1);
    $display("txn bp_lw4 held 3 cycles rdata=0x%08h", rsp_rdata);
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp/valid_drop", 32'(rsp_valid), 32'd0);
    check("bp/ready_back", 32'(req_ready), 32'd1);
    send("bp_next_lbu80", 1'b0, 3'b100, 32'h80, 32'd0, 32'h0000_0080, 1'b0);

    // Reset while a store is waiting
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b000;
    req_addr   = 32'd16;
    req_wdata  = 32'h0000_00AA;
    rsp_ready  = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b1;
    seen_valid = rsp_valid;
    repeat (2) begin
      @(negedge clk);
      seen_valid = seen_valid | rsp_valid;
    end
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen_valid = seen_valid | rsp_valid;
    end
    check("rst_mid/no_valid", 32'(seen_valid), 32'd0);
    $display("txn rst_mid sb16 discarded seen_valid=%0d", seen_valid);
    txn("rst_mid/lbu16", 1'b0, 3'b100, 32'd16, 32'd0, 32'h0000_0010, 1'b0);
    txn("rst_mid/lw8",   1'b0, 3'b010, 32'd8,  32'd0, 32'h0B0A_0908, 1'b0);

    @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
